// File: rtl/fp16_pkg.sv
// Shared fp16 definitions: width, field slices, zero test and the accumulator sequencer state set.
package fp16_pkg;

   localparam int FP16_W        = 16;
   localparam int FP16_SIGN_BIT = 15;
   localparam int FP16_EXP_MSB  = 14;
   localparam int FP16_EXP_LSB  = 10;
   localparam int FP16_FRAC_MSB = 9;
   localparam int FP16_FRAC_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GATHER = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } acc_state_t;

   function automatic logic fp16_sign(input logic [FP16_W-1:0] v);
      return v[FP16_SIGN_BIT];
   endfunction

   // +0 and -0 both count as zero; the sign bit is deliberately ignored.
   function automatic logic is_zero(input logic [FP16_W-1:0] v);
      return (v[FP16_EXP_MSB:FP16_EXP_LSB] == '0) && (v[FP16_FRAC_MSB:FP16_FRAC_LSB] == '0);
   endfunction

endpackage

// File: rtl/fp16_acc_sequencer.sv
// Per-packet fp16 accumulator driving an external adder over valid/ready operand/result channels.
// Optional FP16_ACC_ZERO_SKIP_EN: zero elements bypass the adder (adder does not handle zero operands).
//
// state  | meaning
// IDLE   | wait for first element of a packet, load it straight into acc
// GATHER | wait for next element, latch it into x_q
// ISSUE  | present {acc, x_q} to the adder until accepted
// WAIT   | wait for the adder result, load it into acc
// DONE   | present packet total and element count until taken
module fp16_acc_sequencer
   import fp16_pkg::*;
#(
   parameter int MAX_LEN = 256,
   parameter int CNT_W   = $clog2(MAX_LEN) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [15:0]       s_data,
   input  logic              s_last,
   output logic              add_valid,
   input  logic              add_ready,
   output logic [15:0]       add_a,
   output logic [15:0]       add_b,
   input  logic              sum_valid,
   output logic              sum_ready,
   input  logic [15:0]       sum_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [15:0]       m_data,
   output logic [CNT_W-1:0]  m_count
);

   acc_state_t        state, state_nxt;
   logic [15:0]       acc, acc_nxt;
   logic [15:0]       x_q, x_nxt;
   logic              last_q, last_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;

   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   // Handshakes use the registered ready/valid flags so no input reaches an output combinationally.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      x_nxt     = x_q;
      last_nxt  = last_q;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (s_valid && s_ready) begin
               acc_nxt   = s_data;
               cnt_nxt   = CNT_W'(1);
               state_nxt = s_last ? ST_DONE : ST_GATHER;
            end
         end
         ST_GATHER: begin
            if (s_valid && s_ready) begin
               cnt_nxt = cnt_inc;
`ifdef FP16_ACC_ZERO_SKIP_EN
               if (is_zero(s_data)) begin
                  state_nxt = s_last ? ST_DONE : ST_GATHER;
               end else if (is_zero(acc)) begin
                  acc_nxt   = s_data;
                  state_nxt = s_last ? ST_DONE : ST_GATHER;
               end else begin
                  x_nxt     = s_data;
                  last_nxt  = s_last;
                  state_nxt = ST_ISSUE;
               end
`else
               x_nxt     = s_data;
               last_nxt  = s_last;
               state_nxt = ST_ISSUE;
`endif
            end
         end
         ST_ISSUE: begin
            if (add_valid && add_ready) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (sum_valid && sum_ready) begin
               acc_nxt   = sum_data;
               state_nxt = last_q ? ST_DONE : ST_GATHER;
            end
         end
         ST_DONE: begin
            if (m_valid && m_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         acc       <= '0;
         x_q       <= '0;
         last_q    <= 1'b0;
         cnt       <= '0;
         s_ready   <= 1'b0;
         add_valid <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         sum_ready <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_count   <= '0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         x_q       <= x_nxt;
         last_q    <= last_nxt;
         cnt       <= cnt_nxt;
         s_ready   <= (state_nxt == ST_IDLE) || (state_nxt == ST_GATHER);
         add_valid <= (state_nxt == ST_ISSUE);
         add_a     <= (state_nxt == ST_ISSUE) ? acc_nxt : '0;
         add_b     <= (state_nxt == ST_ISSUE) ? x_nxt : '0;
         sum_ready <= (state_nxt == ST_WAIT);
         m_valid   <= (state_nxt == ST_DONE);
         m_data    <= (state_nxt == ST_DONE) ? acc_nxt : '0;
         m_count   <= (state_nxt == ST_DONE) ? cnt_nxt : '0;
      end
   end

endmodule

// File: tb/tb_fp16_acc_sequencer.sv
// Directed bench for fp16_acc_sequencer; the bench plays source, adder and sink.
module tb_fp16_acc_sequencer;

   localparam int CNT_W = 9;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [15:0]       s_data = '0;
   logic              s_last = 1'b0;
   logic              add_valid;
   logic              add_ready = 1'b0;
   logic [15:0]       add_a;
   logic [15:0]       add_b;
   logic              sum_valid = 1'b0;
   logic              sum_ready;
   logic [15:0]       sum_data = '0;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [15:0]       m_data;
   logic [CNT_W-1:0]  m_count;

   int n_assert = 0;
   int n_fail   = 0;
   int n_issue  = 0;
   int issue_base;

   fp16_acc_sequencer #(.MAX_LEN(256), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .add_valid(add_valid), .add_ready(add_ready), .add_a(add_a), .add_b(add_b),
      .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (add_valid && add_ready) n_issue++;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_ready"},   32'(s_ready),   0);
      chk({tag, "_add_valid"}, 32'(add_valid), 0);
      chk({tag, "_add_a"},     32'(add_a),     0);
      chk({tag, "_add_b"},     32'(add_b),     0);
      chk({tag, "_sum_ready"}, 32'(sum_ready), 0);
      chk({tag, "_m_valid"},   32'(m_valid),   0);
      chk({tag, "_m_data"},    32'(m_data),    0);
      chk({tag, "_m_count"},   32'(m_count),   0);
   endtask

   task automatic send(input logic [15:0] d, input logic last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      for (int i = 0; i < 50 && !s_ready; i++) @(negedge clk);
      chk("s_ready_wait", 32'(s_ready), 1);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Adder model: checks operands, stalls, then returns the hand-computed sum after lat cycles.
   task automatic do_add(input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] sum,
                         input int stall, input int lat);
      for (int i = 0; i < 50 && !add_valid; i++) @(negedge clk);
      chk("add_valid", 32'(add_valid), 1);
      chk("add_a", 32'(add_a), 32'(ea));
      chk("add_b", 32'(add_b), 32'(eb));
      for (int i = 0; i < stall; i++) begin
         sum_valid = 1'b1;
         sum_data  = 16'hDEAD;
         @(negedge clk);
         chk("stall_add_a", 32'(add_a), 32'(ea));
         chk("stall_add_b", 32'(add_b), 32'(eb));
         chk("stall_add_valid", 32'(add_valid), 1);
         chk("stall_sum_ready", 32'(sum_ready), 0);
      end
      sum_valid = 1'b0;
      add_ready = 1'b1;
      @(negedge clk);
      add_ready = 1'b0;
      chk("post_issue_add_valid", 32'(add_valid), 0);
      chk("post_issue_sum_ready", 32'(sum_ready), 1);
      repeat (lat) @(negedge clk);
      sum_valid = 1'b1;
      sum_data  = sum;
      @(negedge clk);
      sum_valid = 1'b0;
      sum_data  = '0;
   endtask

   task automatic expect_done(input logic [15:0] ed, input int ecnt, input int hold);
      for (int i = 0; i < 50 && !m_valid; i++) @(negedge clk);
      chk("m_valid", 32'(m_valid), 1);
      chk("m_data", 32'(m_data), 32'(ed));
      chk("m_count", 32'(m_count), 32'(ecnt));
      chk("done_s_ready", 32'(s_ready), 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_m_valid", 32'(m_valid), 1);
         chk("hold_m_data", 32'(m_data), 32'(ed));
         chk("hold_m_count", 32'(m_count), 32'(ecnt));
         chk("hold_s_ready", 32'(s_ready), 0);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("release_m_valid", 32'(m_valid), 0);
      chk("release_s_ready", 32'(s_ready), 1);
   endtask

   initial begin
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_s_ready", 32'(s_ready), 1);

      // single-element packet: no adder traffic, total the cycle after the transfer
      issue_base = n_issue;
      send(16'h4200, 1'b1);
      chk("single_m_valid_next", 32'(m_valid), 1);
      expect_done(16'h4200, 1, 0);
      chk("single_issues", 32'(n_issue - issue_base), 0);

      // two elements, 1.0 + 2.0 = 3.0
      issue_base = n_issue;
      send(16'h3C00, 1'b0);
      send(16'h4000, 1'b1);
      do_add(16'h3C00, 16'h4000, 16'h4200, 0, 1);
      expect_done(16'h4200, 2, 0);
      chk("two_issues", 32'(n_issue - issue_base), 1);

      // three elements with stalled issues and a held-off sink
      issue_base = n_issue;
      send(16'h3C00, 1'b0);
      send(16'h3C00, 1'b0);
      do_add(16'h3C00, 16'h3C00, 16'h4000, 5, 2);
      send(16'h4000, 1'b1);
      do_add(16'h4000, 16'h4000, 16'h4400, 5, 0);
      expect_done(16'h4400, 3, 10);
      chk("three_issues", 32'(n_issue - issue_base), 2);

      // reset while waiting on the adder
      send(16'h3C00, 1'b0);
      send(16'h4000, 1'b0);
      for (int i = 0; i < 50 && !add_valid; i++) @(negedge clk);
      chk("rst_pre_add_valid", 32'(add_valid), 1);
      add_ready = 1'b1;
      @(negedge clk);
      add_ready = 1'b0;
      chk("rst_pre_sum_ready", 32'(sum_ready), 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(16'h3800, 1'b1);
      chk("post_rst_m_valid", 32'(m_valid), 1);
      expect_done(16'h3800, 1, 0);

      // zero element in the middle of a packet
      issue_base = n_issue;
      send(16'h3C00, 1'b0);
      send(16'h0000, 1'b0);
`ifdef FP16_ACC_ZERO_SKIP_EN
      chk("skip_stays_gather", 32'(s_ready), 1);
      send(16'h4000, 1'b1);
      do_add(16'h3C00, 16'h4000, 16'h4200, 0, 0);
      expect_done(16'h4200, 3, 0);
      chk("zero_issues", 32'(n_issue - issue_base), 1);
`else
      do_add(16'h3C00, 16'h0000, 16'h3C00, 0, 0);
      send(16'h4000, 1'b1);
      do_add(16'h3C00, 16'h4000, 16'h4200, 0, 0);
      expect_done(16'h4200, 3, 0);
      chk("zero_issues", 32'(n_issue - issue_base), 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
